// File: rtl/id_ex_hazard_reg_if.sv
// ID/EX boundary bundle: decoded operands and controls from ID, registered copies toward EX,
// plus the interlock and flush signals exchanged with the front end.
interface id_ex_hazard_reg_if #(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 16
);
  logic                id_valid;
  logic [DATA_W-1:0]   id_Da;
  logic [DATA_W-1:0]   id_Db;
  logic [DATA_W-1:0]   id_imm;
  logic [REG_W-1:0]    id_Rs;
  logic [REG_W-1:0]    id_Rt;
  logic [REG_W-1:0]    id_RegDst;
  logic                id_readRs;
  logic                id_readRt;
  logic                id_RegWrite;
  logic                id_MemRead;
  logic                id_MemWrite;
  logic [ALU_OP_W-1:0] id_ALUop;
  logic                flush;

  logic                stall_if_id;
  logic                ex_valid;
  logic [DATA_W-1:0]   ex_Da;
  logic [DATA_W-1:0]   ex_Db;
  logic [DATA_W-1:0]   ex_imm;
  logic [REG_W-1:0]    ex_Rs;
  logic [REG_W-1:0]    ex_Rt;
  logic [REG_W-1:0]    ex_RegDst;
  logic                ex_readRs;
  logic                ex_readRt;
  logic                ex_RegWrite;
  logic                ex_MemRead;
  logic                ex_MemWrite;
  logic [ALU_OP_W-1:0] ex_ALUop;
  logic [CNT_W-1:0]    stall_count;

  modport master (
    output id_valid, id_Da, id_Db, id_imm, id_Rs, id_Rt, id_RegDst, id_readRs, id_readRt,
           id_RegWrite, id_MemRead, id_MemWrite, id_ALUop, flush,
    input  stall_if_id, ex_valid, ex_Da, ex_Db, ex_imm, ex_Rs, ex_Rt, ex_RegDst, ex_readRs,
           ex_readRt, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUop, stall_count
  );

  modport slave (
    input  id_valid, id_Da, id_Db, id_imm, id_Rs, id_Rt, id_RegDst, id_readRs, id_readRt,
           id_RegWrite, id_MemRead, id_MemWrite, id_ALUop, flush,
    output stall_if_id, ex_valid, ex_Da, ex_Db, ex_imm, ex_Rs, ex_Rt, ex_RegDst, ex_readRs,
           ex_readRt, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUop, stall_count
  );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use interlock, branch flush and saturating stall counter.
//   state | meaning
//   RUN   | normal transfer; a load-use hazard inserts the first bubble here
//   HOLD  | extra bubbles for slow data memory, bcnt_q bubbles still to insert
module id_ex_hazard_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int ALU_OP_W   = 3,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              rst_n,
  id_ex_hazard_reg_if.slave bus
);
  localparam int BC_W = (LOAD_STALL > 1) ? $clog2(LOAD_STALL) : 1;

  typedef enum logic {RUN, HOLD} state_t;

  typedef struct packed {
    logic                valid;
    logic [DATA_W-1:0]   da;
    logic [DATA_W-1:0]   db;
    logic [DATA_W-1:0]   imm;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    reg_dst;
    logic                read_rs;
    logic                read_rt;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic [ALU_OP_W-1:0] alu_op;
  } ex_t;

  state_t           state_q, state_d;
  logic [BC_W-1:0]  bcnt_q, bcnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  ex_t              ex_q, ex_d, id_pkt;
  logic             hazard, stall;

  always_comb begin
    id_pkt.valid     = bus.id_valid;
    id_pkt.da        = bus.id_Da;
    id_pkt.db        = bus.id_Db;
    id_pkt.imm       = bus.id_imm;
    id_pkt.rs        = bus.id_Rs;
    id_pkt.rt        = bus.id_Rt;
    id_pkt.reg_dst   = bus.id_RegDst;
    id_pkt.read_rs   = bus.id_readRs;
    id_pkt.read_rt   = bus.id_readRt;
    id_pkt.reg_write = bus.id_RegWrite;
    id_pkt.mem_read  = bus.id_MemRead;
    id_pkt.mem_write = bus.id_MemWrite;
    id_pkt.alu_op    = bus.id_ALUop;
  end

  // R0 is hard-wired zero, so a load targeting it can never feed a dependent reader.
  assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.reg_dst != '0) && bus.id_valid &&
                  ((bus.id_readRs && (bus.id_Rs == ex_q.reg_dst)) ||
                   (bus.id_readRt && (bus.id_Rt == ex_q.reg_dst)));

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    ex_d    = '0;
    stall   = 1'b0;
    if (bus.flush) begin
      state_d = RUN;
      bcnt_d  = '0;
    end else if (state_q == HOLD) begin
      stall  = 1'b1;
      bcnt_d = bcnt_q - BC_W'(1);
      if (bcnt_q <= BC_W'(1)) state_d = RUN;
    end else if (hazard) begin
      stall = 1'b1;
      if (LOAD_STALL > 1) begin
        state_d = HOLD;
        bcnt_d  = BC_W'(LOAD_STALL - 1);
      end
    end else if (bus.id_valid) begin
      ex_d = id_pkt;
    end
    stall_count_d = (stall && (stall_count_q != '1)) ? stall_count_q + CNT_W'(1) : stall_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      bcnt_q        <= '0;
      stall_count_q <= '0;
      ex_q          <= '0;
    end else begin
      state_q       <= state_d;
      bcnt_q        <= bcnt_d;
      stall_count_q <= stall_count_d;
      ex_q          <= ex_d;
    end
  end

  assign bus.stall_if_id = stall;
  assign bus.stall_count = stall_count_q;
  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_Da       = ex_q.da;
  assign bus.ex_Db       = ex_q.db;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_Rs       = ex_q.rs;
  assign bus.ex_Rt       = ex_q.rt;
  assign bus.ex_RegDst   = ex_q.reg_dst;
  assign bus.ex_readRs   = ex_q.read_rs;
  assign bus.ex_readRt   = ex_q.read_rt;
  assign bus.ex_RegWrite = ex_q.reg_write;
  assign bus.ex_MemRead  = ex_q.mem_read;
  assign bus.ex_MemWrite = ex_q.mem_write;
  assign bus.ex_ALUop    = ex_q.alu_op;
endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench: single-bubble instance driven from a vector table, plus a three-bubble
// instance with a 2-bit counter for the multi-cycle stall, flush, saturation and reset cases.
module tb_id_ex_hazard_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_hazard_reg_if #(.CNT_W(16)) ifa ();
  id_ex_hazard_reg_if #(.CNT_W(2))  ifb ();

  id_ex_hazard_reg #(.LOAD_STALL(1), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  id_ex_hazard_reg #(.LOAD_STALL(3), .CNT_W(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  typedef struct packed {
    logic        valid;
    logic [31:0] da, db, imm;
    logic [4:0]  rs, rt, rd;
    logic        rrs, rrt, rw, mr, mw;
    logic [2:0]  op;
    logic        fl;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic        e_stall, e_valid;
    logic [31:0] e_da, e_db;
    logic [4:0]  e_rs, e_rd;
    logic        e_mr;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic in_t ins(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic rrs, input logic rrt,
                              input logic mr, input logic [31:0] da, input logic [31:0] db,
                              input logic fl);
    in_t t;
    t.valid = v;  t.rs = rs;  t.rt = rt;  t.rd = rd;  t.rrs = rrs;  t.rrt = rrt;
    t.mr = mr;    t.da = da;  t.db = db;  t.imm = da ^ db;  t.rw = 1'b1;  t.mw = 1'b0;
    t.op = 3'd2;  t.fl = fl;
    return t;
  endfunction

  task automatic add_vec(input in_t in, input logic es, input logic ev, input logic [31:0] eda,
                         input logic [31:0] edb, input logic [4:0] ers, input logic [4:0] erd,
                         input logic emr, input logic [15:0] ecnt);
    vec_t v;
    v.in = in;  v.e_stall = es;  v.e_valid = ev;  v.e_da = eda;  v.e_db = edb;
    v.e_rs = ers;  v.e_rd = erd;  v.e_mr = emr;  v.e_cnt = ecnt;
    vecs.push_back(v);
  endtask

  task automatic apply(input in_t t);
    ifa.id_valid = t.valid;  ifa.id_Da = t.da;  ifa.id_Db = t.db;  ifa.id_imm = t.imm;
    ifa.id_Rs = t.rs;  ifa.id_Rt = t.rt;  ifa.id_RegDst = t.rd;  ifa.id_readRs = t.rrs;
    ifa.id_readRt = t.rrt;  ifa.id_RegWrite = t.rw;  ifa.id_MemRead = t.mr;
    ifa.id_MemWrite = t.mw;  ifa.id_ALUop = t.op;  ifa.flush = t.fl;
    ifb.id_valid = t.valid;  ifb.id_Da = t.da;  ifb.id_Db = t.db;  ifb.id_imm = t.imm;
    ifb.id_Rs = t.rs;  ifb.id_Rt = t.rt;  ifb.id_RegDst = t.rd;  ifb.id_readRs = t.rrs;
    ifb.id_readRt = t.rrt;  ifb.id_RegWrite = t.rw;  ifb.id_MemRead = t.mr;
    ifb.id_MemWrite = t.mw;  ifb.id_ALUop = t.op;  ifb.flush = t.fl;
  endtask

  function automatic in_t rnd_in();
    in_t t;
    t = ins(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom));
    return t;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(rnd_in());
      #1;
      chk("rst_a_valid", ifa.ex_valid, 0);
      chk("rst_a_da", ifa.ex_Da, 0);
      chk("rst_a_rd", ifa.ex_RegDst, 0);
      chk("rst_a_cnt", ifa.stall_count, 0);
      chk("rst_a_stall", ifa.stall_if_id, 0);
      chk("rst_b_valid", ifb.ex_valid, 0);
      chk("rst_b_cnt", ifb.stall_count, 0);
      chk("rst_b_stall", ifb.stall_if_id, 0);
      @(negedge clk);
    end
    apply('0);
    rst_n = 1'b1;
  endtask

  // One cycle on the 3-bubble instance: drive, check combinational stall, clock, check EX.
  task automatic step_b(input in_t t, input logic es, input logic ev, input logic [31:0] eda,
                        input logic [1:0] ecnt, input string nm);
    @(negedge clk);
    apply(t);
    #1;
    chk({nm, "_stall"}, ifb.stall_if_id, es);
    @(posedge clk);
    #1;
    chk({nm, "_valid"}, ifb.ex_valid, ev);
    chk({nm, "_da"}, ifb.ex_Da, eda);
    chk({nm, "_cnt"}, ifb.stall_count, ecnt);
  endtask

  initial begin
    in_t lw5, add5;
    lw5  = ins(1, 5'd1, 5'd0, 5'd5, 1, 0, 1, 32'h100, 32'h0, 0);
    add5 = ins(1, 5'd5, 5'd6, 5'd7, 1, 1, 0, 32'hAA, 32'hBB, 0);

    add_vec(ins(1, 3, 4, 6, 1, 1, 0, 32'h11, 32'h22, 0),   0, 1, 32'h11, 32'h22, 3, 6, 0, 0);
    add_vec(lw5,                                           0, 1, 32'h100, 32'h0, 1, 5, 1, 0);
    add_vec(add5,                                          1, 0, 32'h0, 32'h0, 0, 0, 0, 1);
    add_vec(add5,                                          0, 1, 32'hAA, 32'hBB, 5, 7, 0, 1);
    add_vec(ins(1, 0, 0, 0, 0, 0, 1, 32'h30, 32'h0, 0),    0, 1, 32'h30, 32'h0, 0, 0, 1, 1);
    add_vec(ins(1, 0, 0, 8, 1, 1, 0, 32'h33, 32'h34, 0),   0, 1, 32'h33, 32'h34, 0, 8, 0, 1);
    add_vec(ins(1, 2, 0, 5, 1, 0, 1, 32'h44, 32'h0, 0),    0, 1, 32'h44, 32'h0, 2, 5, 1, 1);
    add_vec(ins(1, 2, 5, 9, 1, 0, 0, 32'h55, 32'h56, 0),   0, 1, 32'h55, 32'h56, 2, 9, 0, 1);
    add_vec(ins(1, 2, 0, 5, 1, 0, 1, 32'h66, 32'h0, 0),    0, 1, 32'h66, 32'h0, 2, 5, 1, 1);
    add_vec(ins(1, 2, 5, 10, 1, 1, 0, 32'h57, 32'h58, 0),  1, 0, 32'h0, 32'h0, 0, 0, 0, 2);
    add_vec(ins(1, 2, 5, 10, 1, 1, 0, 32'h57, 32'h58, 0),  0, 1, 32'h57, 32'h58, 2, 10, 0, 2);
    add_vec(ins(1, 2, 0, 5, 1, 0, 1, 32'h77, 32'h0, 0),    0, 1, 32'h77, 32'h0, 2, 5, 1, 2);
    add_vec(ins(0, 5, 5, 11, 1, 1, 0, 32'h99, 32'h98, 0),  0, 0, 32'h0, 32'h0, 0, 0, 0, 2);
    add_vec(ins(1, 2, 0, 5, 1, 0, 1, 32'h88, 32'h0, 0),    0, 1, 32'h88, 32'h0, 2, 5, 1, 2);
    add_vec(ins(1, 5, 6, 12, 1, 1, 0, 32'hAB, 32'hAC, 1),  0, 0, 32'h0, 32'h0, 0, 0, 0, 2);
    add_vec(ins(1, 5, 6, 12, 1, 1, 0, 32'hAB, 32'hAC, 0),  0, 1, 32'hAB, 32'hAC, 5, 12, 0, 2);
    add_vec(ins(1, 2, 0, 5, 1, 0, 1, 32'h12, 32'h0, 0),    0, 1, 32'h12, 32'h0, 2, 5, 1, 2);
    add_vec(ins(1, 21, 20, 13, 1, 1, 0, 32'h13, 32'h14, 0), 0, 1, 32'h13, 32'h14, 21, 13, 0, 2);

    apply('0);
    do_reset();

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i].in);
      #1;
      chk($sformatf("v%0d_stall", i), ifa.stall_if_id, vecs[i].e_stall);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), ifa.ex_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_da", i), ifa.ex_Da, vecs[i].e_da);
      chk($sformatf("v%0d_db", i), ifa.ex_Db, vecs[i].e_db);
      chk($sformatf("v%0d_imm", i), ifa.ex_imm, vecs[i].e_da ^ vecs[i].e_db);
      chk($sformatf("v%0d_rs", i), ifa.ex_Rs, vecs[i].e_rs);
      chk($sformatf("v%0d_rd", i), ifa.ex_RegDst, vecs[i].e_rd);
      chk($sformatf("v%0d_mr", i), ifa.ex_MemRead, vecs[i].e_mr);
      chk($sformatf("v%0d_rw", i), ifa.ex_RegWrite, vecs[i].e_valid);
      chk($sformatf("v%0d_cnt", i), ifa.stall_count, vecs[i].e_cnt);
    end

    // Three-bubble interlock, then a second hazard to push the 2-bit counter past its limit.
    do_reset();
    step_b(lw5,  0, 1, 32'h100, 2'd0, "ls3_lw");
    step_b(add5, 1, 0, 32'h0,   2'd1, "ls3_b1");
    step_b(add5, 1, 0, 32'h0,   2'd2, "ls3_b2");
    step_b(add5, 1, 0, 32'h0,   2'd3, "ls3_b3");
    step_b(add5, 0, 1, 32'hAA,  2'd3, "ls3_add");
    step_b(lw5,  0, 1, 32'h100, 2'd3, "sat_lw");
    step_b(add5, 1, 0, 32'h0,   2'd3, "sat_b1");
    step_b(add5, 1, 0, 32'h0,   2'd3, "sat_b2");
    step_b(add5, 1, 0, 32'h0,   2'd3, "sat_b3");
    step_b(add5, 0, 1, 32'hAA,  2'd3, "sat_add");

    // Flush in the second stall cycle ends the hold early.
    do_reset();
    step_b(lw5,  0, 1, 32'h100, 2'd0, "fl_lw");
    step_b(add5, 1, 0, 32'h0,   2'd1, "fl_b1");
    add5.fl = 1'b1;
    step_b(add5, 0, 0, 32'h0,   2'd1, "fl_flush");
    add5.fl = 1'b0;
    step_b(add5, 0, 1, 32'hAA,  2'd1, "fl_add");

    // Asynchronous reset while holding; first cycle after release runs without a stall.
    do_reset();
    step_b(lw5,  0, 1, 32'h100, 2'd0, "mr_lw");
    step_b(add5, 1, 0, 32'h0,   2'd1, "mr_b1");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_rst_stall", ifb.stall_if_id, 0);
    chk("mr_rst_cnt", ifb.stall_count, 0);
    chk("mr_rst_valid", ifb.ex_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step_b(add5, 0, 1, 32'hAA, 2'd0, "mr_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
